// File: rtl/digital_pattern_generator.sv
// Serial pattern playback: reads NUM_WORDS words from BRAM and drives them LSB-first on signal_out.
// Define PATTERN_LOOP_EN to replay the pattern continuously instead of stopping in DONE.
module digital_pattern_generator #(
    parameter int unsigned SAMPLE_DIVIDER_RATIO = 50,
    parameter int unsigned NUM_WORDS            = 32,
    parameter logic        IDLE_LEVEL           = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_play,
    input  logic        ack,
    output logic        bram_re,
    output logic [4:0]  bram_raddr,
    input  logic [31:0] bram_rdata,
    output logic        signal_out,
    output logic        busy,
    output logic        play_done,
    output logic [2:0]  debug_state_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PLAYING = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int unsigned      DIV_W     = $clog2(SAMPLE_DIVIDER_RATIO);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIVIDER_RATIO - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [4:0]       LAST_WORD = 5'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic              start_dly_q, ack_dly_q;
    logic              bram_re_q, bram_re_d;
    logic [4:0]        bram_raddr_q, bram_raddr_d;
    logic              signal_out_q, signal_out_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       prefetch_q, prefetch_d;
    logic              pf_cap_q, pf_cap_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [4:0]        word_cnt_q, word_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
`ifdef PATTERN_LOOP_EN
    logic              wrap_q, wrap_d;
`endif

    logic start_pulse, ack_pulse, tick;

    assign start_pulse = start_play & ~start_dly_q;
    assign ack_pulse   = ack & ~ack_dly_q;
    assign tick        = (div_cnt_q == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational process below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            start_dly_q  <= 1'b0;
            ack_dly_q    <= 1'b0;
            bram_re_q    <= 1'b0;
            bram_raddr_q <= '0;
            signal_out_q <= IDLE_LEVEL;
            shift_q      <= '0;
            prefetch_q   <= '0;
            pf_cap_q     <= 1'b0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            div_cnt_q    <= '0;
`ifdef PATTERN_LOOP_EN
            wrap_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_dly_q  <= start_play;
            ack_dly_q    <= ack;
            bram_re_q    <= bram_re_d;
            bram_raddr_q <= bram_raddr_d;
            signal_out_q <= signal_out_d;
            shift_q      <= shift_d;
            prefetch_q   <= prefetch_d;
            pf_cap_q     <= pf_cap_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            div_cnt_q    <= div_cnt_d;
`ifdef PATTERN_LOOP_EN
            wrap_q       <= wrap_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every target gets a default first; this is what keeps the case
        // statement below from inferring latches on the branches that skip it.
        state_d      = state_q;
        bram_re_d    = 1'b0;
        bram_raddr_d = bram_raddr_q;
        signal_out_d = signal_out_q;
        shift_d      = shift_q;
        prefetch_d   = pf_cap_q ? bram_rdata : prefetch_q;
        pf_cap_d     = bram_re_q && (state_q == ST_PLAYING);
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        div_cnt_d    = div_cnt_q;
`ifdef PATTERN_LOOP_EN
        wrap_d       = 1'b0;
`endif

        if (ack_pulse) begin
            state_d      = ST_IDLE;
            signal_out_d = IDLE_LEVEL;
            pf_cap_d     = 1'b0;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            div_cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    div_cnt_d  = '0;
                    if (start_pulse) begin
                        bram_re_d    = 1'b1;
                        bram_raddr_d = '0;
                        state_d      = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_LOAD;
                ST_LOAD: begin
                    shift_d      = bram_rdata;
                    signal_out_d = bram_rdata[0];
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                    div_cnt_d    = '0;
                    state_d      = ST_PLAYING;
                end
                ST_PLAYING: begin
                    if (!tick) begin
                        div_cnt_d = div_cnt_q + DIV_ONE;
                    end else begin
                        div_cnt_d = '0;
                        if (bit_cnt_q == 5'd31) begin
                            if (word_cnt_q < LAST_WORD) begin
                                shift_d      = prefetch_q;
                                signal_out_d = prefetch_q[0];
                                word_cnt_d   = word_cnt_q + 5'd1;
                                bit_cnt_d    = '0;
                            end else begin
`ifdef PATTERN_LOOP_EN
                                shift_d      = prefetch_q;
                                signal_out_d = prefetch_q[0];
                                word_cnt_d   = '0;
                                bit_cnt_d    = '0;
                                wrap_d       = 1'b1;
`else
                                signal_out_d = IDLE_LEVEL;
                                state_d      = ST_DONE;
`endif
                            end
                        end else begin
                            bit_cnt_d    = bit_cnt_q + 5'd1;
                            shift_d      = shift_q >> 1;
                            signal_out_d = shift_q[1];
                            // Fetch the next word early so it is ready at the boundary.
                            if (bit_cnt_q == 5'd0) begin
`ifdef PATTERN_LOOP_EN
                                bram_re_d    = 1'b1;
                                bram_raddr_d = (word_cnt_q < LAST_WORD) ? word_cnt_q + 5'd1 : 5'd0;
`else
                                if (word_cnt_q < LAST_WORD) begin
                                    bram_re_d    = 1'b1;
                                    bram_raddr_d = word_cnt_q + 5'd1;
                                end
`endif
                            end
                        end
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_PLAYING);
`ifdef PATTERN_LOOP_EN
        play_done       = wrap_q;
`else
        play_done       = (state_q == ST_DONE);
`endif
        debug_state_out = state_q;
        bram_re         = bram_re_q;
        bram_raddr      = bram_raddr_q;
        signal_out      = signal_out_q;
    end

endmodule
